// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a start/busy handshake.
// Each popped byte gets one tx_en_o pulse; a transmitter that never goes busy trips timeout_o.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [7:0]                 wr_data_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    input  logic                       clr_ovf_i,
    output logic [7:0]                 tx_data_o,
    output logic                       tx_en_o,
    input  logic                       tx_busy_i,
    output logic                       timeout_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_C  = DEPTH[AW:0];
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q;
    logic [TW-1:0] tmo_cnt;
    logic          push, pop, tmo_hit;

    assign count_o = count_q;
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign tx_en_o = (state_q == START);

    // A write while full is dropped outright, even if a pop frees a slot on the same edge.
    assign push    = wr_en_i && !full_o;
    assign pop     = (state_q == IDLE) && !empty_o && !tx_busy_i;
    assign tmo_hit = (state_q == WAIT_HI) && !tx_busy_i && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = START;
            START:   state_d = WAIT_HI;
            WAIT_HI: begin
                if (tx_busy_i)    state_d = WAIT_LO;
                else if (tmo_hit) state_d = IDLE;
            end
            WAIT_LO: if (!tx_busy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Storage has no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            tx_data_o  <= 8'h00;
            tmo_cnt    <= '0;
            overflow_o <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                tx_data_o <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (state_q == START)
                tmo_cnt <= '0;
            else if (state_q == WAIT_HI && !tx_busy_i)
                tmo_cnt <= tmo_cnt + 1'b1;

            // A fresh event on the clearing edge wins over the clear.
            if (wr_en_i && full_o) overflow_o <= 1'b1;
            else if (clr_ovf_i)    overflow_o <= 1'b0;
            if (tmo_hit)           timeout_o  <= 1'b1;
            else if (clr_ovf_i)    timeout_o  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, latency, fill/overflow, drain order,
// pointer wrap, busy timeout with clear priority, and reset mid-handshake.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en_i;
    logic [7:0] wr_data_i;
    logic       full_o, empty_o, overflow_o, clr_ovf_i;
    logic [4:0] count_o;
    logic [7:0] tx_data_o;
    logic       tx_en_o, tx_busy_i, timeout_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] got[$];

    uart_tx_fifo #(.DEPTH(16), .BUSY_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
        .overflow_o(overflow_o), .clr_ovf_i(clr_ovf_i), .tx_data_o(tx_data_o),
        .tx_en_o(tx_en_o), .tx_busy_i(tx_busy_i), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; wr_en_i = 1'b0; wr_data_i = 8'h00; clr_ovf_i = 1'b0; tx_busy_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Writer pushes whenever not full; transmitter model raises busy one cycle
    // after each start pulse and holds it for 'hold' cycles.
    task automatic run_stream(input int n_wr, input logic [7:0] base, input int hold,
                              input int max_cyc, input int n_exp,
                              output int viol, output int done);
        int wr_i = 0;
        int arm  = 0;
        int left = 0;
        viol = 0; done = 0;
        got.delete();
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (left > 0) begin
                left--;
                if (left == 0) tx_busy_i = 1'b0;
            end
            if (arm != 0) begin
                arm = 0; tx_busy_i = 1'b1; left = hold;
            end
            if (tx_en_o) begin
                got.push_back(tx_data_o);
                arm = 1;
            end
            if (wr_i < n_wr && !full_o) begin
                wr_en_i = 1'b1; wr_data_i = base + 8'(wr_i); wr_i++;
            end else begin
                wr_en_i = 1'b0;
            end
            if (got.size() == n_exp && wr_i == n_wr && arm == 0 && left == 0) begin
                done = 1;
                break;
            end
        end
        wr_en_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en_i = 1'b0; wr_data_i = 8'h00; clr_ovf_i = 1'b0; tx_busy_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({count_o, empty_o, full_o, overflow_o, timeout_o, tx_data_o, tx_en_o} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b ovf=%b tmo=%b data=%h en=%b, expected 0 1 0 0 0 00 0",
                     count_o, empty_o, full_o, overflow_o, timeout_o, tx_data_o, tx_en_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        do_reset();
        wr_en_i = 1'b1; wr_data_i = 8'hA5;
        @(negedge clk);
        wr_en_i = 1'b0;
        checks++;
        if (tx_en_o !== 1'b0 || count_o !== 5'd1) begin
            errors++;
            $display("FAIL single_cycle1: en=%b count=%0d, expected en=0 count=1", tx_en_o, count_o);
        end
        @(negedge clk);
        checks++;
        if (tx_en_o !== 1'b1 || tx_data_o !== 8'hA5 || count_o !== 5'd0) begin
            errors++;
            $display("FAIL single_cycle2: en=%b data=%h count=%0d, expected en=1 data=a5 count=0",
                     tx_en_o, tx_data_o, count_o);
        end
        @(negedge clk);
        tx_busy_i = 1'b1;
        repeat (2) @(negedge clk);
        tx_busy_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (empty_o !== 1'b1 || timeout_o !== 1'b0 || tx_en_o !== 1'b0) begin
            errors++;
            $display("FAIL single_after: empty=%b tmo=%b en=%b, expected 1 0 0", empty_o, timeout_o, tx_en_o);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        tx_busy_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                checks++;
                if (full_o !== 1'b1 || count_o !== 5'd16 || overflow_o !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_16: full=%b count=%0d ovf=%b, expected 1 16 0", full_o, count_o, overflow_o);
                end
            end
            wr_en_i = 1'b1; wr_data_i = 8'(i);
            @(negedge clk);
        end
        wr_en_i = 1'b0;
        checks++;
        if (full_o !== 1'b1 || count_o !== 5'd16 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL fill_drop: full=%b count=%0d ovf=%b, expected 1 16 1", full_o, count_o, overflow_o);
        end
        wr_en_i = 1'b1; wr_data_i = 8'hEE; clr_ovf_i = 1'b1;
        @(negedge clk);
        wr_en_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b1 || count_o !== 5'd16) begin
            errors++;
            $display("FAIL ovf_priority: ovf=%b count=%0d, expected 1 16", overflow_o, count_o);
        end
        @(negedge clk);
        clr_ovf_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, expected 0", overflow_o);
        end
    endtask

    task automatic test_drain_order();
        int viol, done, bad;
        tx_busy_i = 1'b0;
        run_stream(0, 8'h00, 10, 600, 16, viol, done);
        checks++;
        if (done !== 1 || got.size() !== 16) begin
            errors++;
            $display("FAIL drain_count: done=%0d bytes=%0d, expected 1 16", done, got.size());
        end
        bad = 0;
        foreach (got[i]) if (got[i] !== 8'(i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL drain_order: %0d bytes out of order, expected 0", bad);
        end
        checks++;
        if (viol !== 0 || empty_o !== 1'b1 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_state: busy_pulses=%0d empty=%b tmo=%b, expected 0 1 0", viol, empty_o, timeout_o);
        end
    endtask

    task automatic test_wrap();
        int viol, done, bad;
        do_reset();
        run_stream(40, 8'h40, 1, 600, 40, viol, done);
        bad = 0;
        foreach (got[i]) if (got[i] !== 8'h40 + 8'(i)) bad++;
        checks++;
        if (done !== 1 || got.size() !== 40 || bad !== 0) begin
            errors++;
            $display("FAIL wrap_order: done=%0d bytes=%0d bad=%0d, expected 1 40 0", done, got.size(), bad);
        end
        checks++;
        if (empty_o !== 1'b1 || overflow_o !== 1'b0 || timeout_o !== 1'b0 || viol !== 0) begin
            errors++;
            $display("FAIL wrap_end: empty=%b ovf=%b tmo=%b viol=%0d, expected 1 0 0 0",
                     empty_o, overflow_o, timeout_o, viol);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        wr_en_i = 1'b1; wr_data_i = 8'h3C;
        @(negedge clk);
        wr_en_i = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_en_o !== 1'b1 || tx_data_o !== 8'h3C) begin
            errors++;
            $display("FAIL tmo_start: en=%b data=%h, expected 1 3c", tx_en_o, tx_data_o);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early: tmo=%b, expected 0", timeout_o);
        end
        @(negedge clk);
        checks++;
        if (timeout_o !== 1'b1 || empty_o !== 1'b1) begin
            errors++;
            $display("FAIL tmo_set: tmo=%b empty=%b, expected 1 1", timeout_o, empty_o);
        end
        wr_en_i = 1'b1; wr_data_i = 8'h5A;
        @(negedge clk);
        wr_en_i = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_en_o !== 1'b1 || tx_data_o !== 8'h5A) begin
            errors++;
            $display("FAIL tmo_next: en=%b data=%h, expected 1 5a", tx_en_o, tx_data_o);
        end
        @(negedge clk);
        clr_ovf_i = 1'b1;
        @(negedge clk);
        clr_ovf_i = 1'b0;
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear: tmo=%b, expected 0", timeout_o);
        end
        repeat (6) @(negedge clk);
        clr_ovf_i = 1'b1;
        @(negedge clk);
        checks++;
        if (timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL tmo_priority: tmo=%b, expected 1", timeout_o);
        end
        @(negedge clk);
        clr_ovf_i = 1'b0;
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear2: tmo=%b, expected 0", timeout_o);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_en_i = 1'b1; wr_data_i = 8'h80 + 8'(i);
            @(negedge clk);
            if (tx_en_o) tx_busy_i = 1'b1;
        end
        wr_en_i = 1'b0;
        @(negedge clk);
        checks++;
        if (count_o !== 5'd3 || tx_busy_i !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup: count=%0d busy=%b, expected 3 1", count_o, tx_busy_i);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({count_o, empty_o, full_o, overflow_o, timeout_o, tx_data_o, tx_en_o} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_async: count=%0d empty=%b full=%b ovf=%b tmo=%b data=%h en=%b, expected 0 1 0 0 0 00 0",
                     count_o, empty_o, full_o, overflow_o, timeout_o, tx_data_o, tx_en_o);
        end
        @(negedge clk);
        rst = 1'b0; tx_busy_i = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tx_en_o) stray++;
        end
        checks++;
        if (stray !== 0 || empty_o !== 1'b1 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: pulses=%0d empty=%b tmo=%b, expected 0 1 0", stray, empty_o, timeout_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_drain_order();
        test_wrap();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries; it SHALL be a power of two, at least 2.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 8, meaning the maximum cycles to wait for tx_busy_i to rise after a start pulse.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port wr_en_i, input, 1 bit: write strobe.
REQ-006 SHALL have port wr_data_i, input, 8 bits: byte to enqueue.
REQ-007 SHALL have port full_o, output, 1 bit: high when count_o equals DEPTH.
REQ-008 SHALL have port empty_o, output, 1 bit: high when count_o equals 0.
REQ-009 SHALL have port count_o, output, log2(DEPTH)+1 bits: current occupancy.
REQ-010 SHALL have port overflow_o, output, 1 bit: sticky flag for a write dropped while full.
REQ-011 SHALL have port clr_ovf_i, input, 1 bit: synchronous clear of overflow_o and timeout_o.
REQ-012 SHALL have port tx_data_o, output, 8 bits: byte presented to the UART transmitter.
REQ-013 SHALL have port tx_en_o, output, 1 bit: one-cycle start pulse to the transmitter.
REQ-014 SHALL have port tx_busy_i, input, 1 bit: transmitter busy flag.
REQ-015 SHALL have port timeout_o, output, 1 bit: sticky flag set when tx_busy_i did not rise within BUSY_TIMEOUT cycles.

Function
REQ-016 SHALL accept a write on a clock edge where wr_en_i=1 and full_o=0: store wr_data_i at the write pointer, advance the write pointer modulo DEPTH, and increment the count.
REQ-017 SHALL drop a write on an edge where wr_en_i=1 and full_o=1, set overflow_o=1, and leave all FIFO contents, pointers and count unchanged; no write-through while full, even if a pop occurs on the same edge.
REQ-018 SHALL leave the count unchanged when a push and a pop occur on the same edge; pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 SHALL derive full_o, empty_o and count_o from registered count only; they SHALL reflect a push or pop from the next cycle onward.
REQ-020 SHALL implement a four-state FSM: IDLE, START, WAIT_HI, WAIT_LO.
REQ-021 In IDLE, if empty_o=0 and tx_busy_i=0, the FSM SHALL, on that edge, load the head byte into tx_data_o, advance the read pointer (pop), and go to START; otherwise it SHALL stay in IDLE.
REQ-022 In START, tx_en_o SHALL be 1 for exactly that cycle; the FSM SHALL then go to WAIT_HI and clear its timeout counter.
REQ-023 In WAIT_HI, if tx_busy_i=1, the FSM SHALL go to WAIT_LO.
REQ-024 In WAIT_HI, if BUSY_TIMEOUT cycles elapse with tx_busy_i=0, the FSM SHALL set timeout_o=1 and go to IDLE; the byte is lost and is not re-queued.
REQ-025 In WAIT_LO, the FSM SHALL stay while tx_busy_i=1 and go to IDLE on the first edge where tx_busy_i=0.
REQ-026 SHALL hold tx_data_o stable from the START cycle until the next pop; tx_en_o SHALL be 0 in every state except START.
REQ-027 Latency: a byte written into an empty FIFO with tx_busy_i=0 SHALL produce tx_en_o=1 in the second cycle after the wr_en_i cycle.
REQ-028 On clr_ovf_i=1, SHALL clear overflow_o and timeout_o; a new overflow or timeout on the same edge SHALL take priority, leaving the flag at 1.

Reset
REQ-029 While rst=1, regardless of clk, SHALL force: pointers=0, count_o=0, empty_o=1, full_o=0, overflow_o=0, timeout_o=0, tx_data_o=8'h00, tx_en_o=0, FSM in IDLE.
REQ-030 Reset mid-operation SHALL discard all queued bytes and any in-flight handshake; after rst falls, no tx_en_o SHALL occur until a new write.

Verification
REQ-031 Single byte: with tx_busy_i=0, write 8'hA5 in cycle 0 -> tx_en_o=1 in cycle 2 with tx_data_o=8'hA5; count_o returns to 0.
REQ-032 Fill: write 17 bytes 0..16 back-to-back with tx_busy_i=1 -> full_o=1 after 16 writes, byte 16 dropped, overflow_o=1, count_o=16.
REQ-033 Drain order: release tx_busy_i; the transmitter model raises busy 1 cycle after each tx_en_o for 10 cycles -> bytes 0..15 are emitted in order, one tx_en_o per byte, with no pulse while tx_busy_i=1.
REQ-034 Wrap: with DEPTH=16, push and pop 40 bytes continuously -> all 40 bytes are emitted in order and empty_o=1 at the end.
REQ-035 Timeout: tx_busy_i held 0 after a start pulse -> timeout_o=1 after 8 cycles, FSM back in IDLE, next byte starts normally; clr_ovf_i clears the flag.
REQ-036 Reset in WAIT_LO with 3 bytes queued -> all outputs take their reset values immediately, and no tx_en_o occurs after release.
